zle_b_dec: RTL and testbench
============================

// Module: zle_B_dec
// PURPOSE
//  Zero run-length decoder; the downstream partner of the ZLE encoder stage.
//  - Consumes the 8-bit encoded token stream.
//  - Reconstructs the original 7-bit symbol stream.
//  - Expands each run token into N zero symbols.
//  - Valid/ready handshake on both sides. Registered output. Sustains 1 symbol/cycle.
// PARAMETERS
//  SW    7   symbol width. Token width is SW+1.
//  RW    8   run-remaining counter width. Must hold 2**SW.
// PORTS
//  clock       in   1     rising-edge clock
//  reset       in   1     synchronous, active-low reset
//  i_d         in   8     encoded token
//  i_valid     in   1     i_d is valid this cycle
//  i_ready     out  1     decoder accepts i_d this cycle
//  o_d         out  7     decoded symbol
//  o_valid     out  1     o_d is valid
//  o_ready     in   1     consumer accepts o_d this cycle
//  run_active  out  1     high while a zero run is still being expanded
// BEHAVIOUR
//  - Clock and reset: one clock. Reset is synchronous, active-low, sampled on posedge clock.
//  - Token format:
//    - i_d[7]==0 is a literal; the symbol is i_d[6:0].
//    - i_d[7]==1 is a zero run of length L=i_d[6:0]. L==0 means L=128.
//  - Handshakes:
//    - An input transfer happens when i_valid & i_ready.
//    - An output transfer happens when o_valid & o_ready.
//    - slot_free = !o_valid | o_ready.
//  - States:
//    - ST_START=0: i_ready=slot_free.
//      - Accepted literal: o_d<=i_d[6:0], o_valid<=1, stay in ST_START.
//      - Accepted run with L==1: o_d<=0, o_valid<=1, stay in ST_START.
//      - Accepted run with L>1: o_d<=0, o_valid<=1, rem<=L-1, go to ST_RUN.
//      - No transfer while slot_free: o_valid<=0.
//    - ST_RUN=1: i_ready=0 (combinational). run_active=1.
//      - When slot_free: o_d<=0, o_valid<=1, rem<=rem-1.
//      - If rem==1 at that edge, go to ST_START.
//      - When !slot_free: hold all state.
//  - Latency: token accepted at edge k gives its first symbol valid after edge k.
//    Back-to-back literals stream at 1 per cycle.
//  - A run of L yields exactly L zeros on L consecutive edges when o_ready is held high.
//    The next token is accepted on the edge carrying the last zero.
//  - Backpressure: while o_valid & !o_ready, o_d, o_valid, rem and state are frozen.
//    i_ready=0 in this case.
//  - i_ready never depends on i_valid. o_valid never depends on o_ready (no comb loop).
//  - rem arithmetic is RW-bit unsigned. It never wraps: it stays in 1..127 while in ST_RUN.
//  - Reset values: o_valid=0, o_d=0, i_ready=0 during reset, run_active=0, state=ST_START, rem=0.
//  - Reset mid-run abandons the remaining zeros. The first token after reset is decoded fresh.
//  - Undefined state encoding: recover to ST_START with o_valid=0.
// CONFIGURATION
//  ZLE_DEC_STATS_EN
//    defined:
//      - Adds output ports n_tok[31:0] and n_zero[31:0].
//      - n_tok counts accepted tokens. n_zero counts emitted zero symbols,
//        from both literals equal to 0 and runs.
//      - Both counters clear on reset and wrap modulo 2**32.
//      - Neither counter affects the datapath timing.
//    undefined:
//      - No extra ports or registers. Behaviour is otherwise identical.
// TESTING
//  T1 literals 0x05,0x41,0x7F with o_ready=1
//     -> o_d 05,41,7F on 3 consecutive cycles; i_ready stays 1.
//  T2 run token 0x83 followed by literal 0x09
//     -> o_d 00,00,00,09.
//     -> i_ready=0 for exactly 2 cycles.
//     -> run_active high for those 2 cycles.
//  T3 run token 0x80 (L=128)
//     -> exactly 128 zeros, then the next token accepted on the 128th output edge.
//  T4 run 0x84 with o_ready toggling 1,0,0,1,1,0,1
//     -> 4 zeros total.
//     -> o_d/o_valid stable while o_ready=0.
//     -> no token accepted until the last zero transfers.
//  T5 reset=0 asserted after 2 of 10 zeros of token 0x8A
//     -> o_valid=0 next cycle; rem discarded.
//     -> literal 0x11 after reset yields only 0x11.
//  T6 random tokens vs reference model expanding runs, random o_ready/i_valid
//     -> output sequence identical.
//     -> with ZLE_DEC_STATS_EN: n_tok and n_zero match the model.

Source files
------------

// File: rtl/zle_b_dec.sv
// Zero run-length decoder: literal tokens pass through, run tokens expand to N zeros.
// Optional token/zero statistics counters are enabled with ZLE_DEC_STATS_EN.
module zle_b_dec #(
  parameter int unsigned SW = 7,
  parameter int unsigned RW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [SW:0]   i_d,
  input  logic          i_valid,
  output logic          i_ready,
  output logic [SW-1:0] o_d,
  output logic          o_valid,
  input  logic          o_ready,
  output logic          run_active
`ifdef ZLE_DEC_STATS_EN
  ,
  output logic [31:0]   n_tok,
  output logic [31:0]   n_zero
`endif
);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_RUN   = 2'd1
  } state_t;

  state_t        state, state_n;
  logic [RW-1:0] rem, rem_n;
  logic [SW-1:0] o_d_n;
  logic          o_valid_n;

  logic          slot_free;
  logic          accept;
  logic          tok_run;
  logic [SW-1:0] tok_len;
  logic [RW-1:0] run_len;

  assign slot_free  = !o_valid || o_ready;
  // i_ready is forced low while reset is held so nothing is taken mid-reset.
  assign i_ready    = reset && (state == ST_START) && slot_free;
  assign run_active = (state == ST_RUN);
  assign accept     = i_valid && i_ready;
  assign tok_run    = i_d[SW];
  assign tok_len    = i_d[SW-1:0];
  assign run_len    = (tok_len == '0) ? RW'(2**SW) : RW'(tok_len);

  always_comb begin
    state_n   = state;
    rem_n     = rem;
    o_d_n     = o_d;
    o_valid_n = o_valid;
    case (state)
      ST_START: begin
        if (accept) begin
          o_valid_n = 1'b1;
          if (!tok_run) begin
            o_d_n = tok_len;
          end else begin
            o_d_n = '0;
            if (run_len != RW'(1)) begin
              rem_n   = run_len - RW'(1);
              state_n = ST_RUN;
            end
          end
        end else if (slot_free) begin
          o_valid_n = 1'b0;
        end
      end
      ST_RUN: begin
        if (slot_free) begin
          o_d_n     = '0;
          o_valid_n = 1'b1;
          rem_n     = rem - RW'(1);
          if (rem == RW'(1)) state_n = ST_START;
        end
      end
      default: begin
        state_n   = ST_START;
        rem_n     = '0;
        o_valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= ST_START;
      rem     <= '0;
      o_d     <= '0;
      o_valid <= 1'b0;
    end else begin
      state   <= state_n;
      rem     <= rem_n;
      o_d     <= o_d_n;
      o_valid <= o_valid_n;
    end
  end

`ifdef ZLE_DEC_STATS_EN
  // Zeros are counted as they are loaded into the output register.
  logic zero_load;
  assign zero_load = (accept && (tok_run || (tok_len == '0))) ||
                     ((state == ST_RUN) && slot_free);

  always_ff @(posedge clock) begin
    if (!reset) begin
      n_tok  <= '0;
      n_zero <= '0;
    end else begin
      if (accept)    n_tok  <= n_tok + 32'd1;
      if (zero_load) n_zero <= n_zero + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_zle_b_dec.sv
// Directed and randomized bench for the zero run-length decoder zle_b_dec.
module tb_zle_b_dec;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] i_d;
  logic       i_valid;
  logic       i_ready;
  logic [6:0] o_d;
  logic       o_valid;
  logic       o_ready;
  logic       run_active;
`ifdef ZLE_DEC_STATS_EN
  logic [31:0] n_tok;
  logic [31:0] n_zero;
`endif

  int n_vec = 0;
  int n_err = 0;

  zle_b_dec #(.SW(7), .RW(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .i_d        (i_d),
    .i_valid    (i_valid),
    .i_ready    (i_ready),
    .o_d        (o_d),
    .o_valid    (o_valid),
    .o_ready    (o_ready),
    .run_active (run_active)
`ifdef ZLE_DEC_STATS_EN
    ,
    .n_tok      (n_tok),
    .n_zero     (n_zero)
`endif
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gen_tok();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 0)      return 8'h00;
    else if (r < 5)  return {1'b0, 7'($urandom_range(0, 127))};
    else if (r < 8)  return {1'b1, 7'($urandom_range(1, 5))};
    else if (r == 8) return {1'b1, 7'($urandom_range(6, 20))};
    else             return ($urandom_range(0, 3) == 0) ? 8'h80 : 8'h82;
  endfunction

  initial begin
    logic [6:0]  q[$];
    logic [7:0]  cur_tok;
    logic        orpat[7];
    logic        irexp[7];
    int          cyc, zeros, low, xfer, len;
    int unsigned m_tok, m_zero;

    orpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    irexp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset
    reset = 1'b0; i_valid = 1'b0; i_d = 8'h00; o_ready = 1'b1;
    tick(); tick();
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_d", o_d, 0);
    chk("rst_run_active", run_active, 0);
    chk("rst_i_ready", i_ready, 0);
`ifdef ZLE_DEC_STATS_EN
    chk("rst_n_tok", n_tok, 0);
    chk("rst_n_zero", n_zero, 0);
`endif
    reset = 1'b1; #1;
    chk("post_rst_i_ready", i_ready, 1);

    // T1 literals stream at one per cycle
    i_valid = 1'b1; i_d = 8'h05; #1;
    chk("t1_ir0", i_ready, 1);
    tick(); chk("t1_d0", o_d, 7'h05); chk("t1_v0", o_valid, 1);
    i_d = 8'h41; #1; chk("t1_ir1", i_ready, 1);
    tick(); chk("t1_d1", o_d, 7'h41);
    i_d = 8'h7F; #1; chk("t1_ir2", i_ready, 1);
    tick(); chk("t1_d2", o_d, 7'h7F);
    i_valid = 1'b0;
    tick(); chk("t1_idle_v", o_valid, 0);

    // T2 run of 3 then literal 0x09
    i_valid = 1'b1; i_d = 8'h83; #1;
    chk("t2_ir_acc", i_ready, 1);
    tick(); chk("t2_z0", o_d, 0); chk("t2_v0", o_valid, 1);
    i_d = 8'h09; #1;
    chk("t2_ir_a", i_ready, 0); chk("t2_ra_a", run_active, 1);
    tick(); chk("t2_z1", o_d, 0); chk("t2_v1", o_valid, 1);
    chk("t2_ir_b", i_ready, 0); chk("t2_ra_b", run_active, 1);
    tick(); chk("t2_z2", o_d, 0); chk("t2_v2", o_valid, 1);
    chk("t2_ir_c", i_ready, 1); chk("t2_ra_c", run_active, 0);
    tick(); chk("t2_lit", o_d, 7'h09); chk("t2_vl", o_valid, 1);
    i_valid = 1'b0; tick();

    // T3 run of 128, next literal queued behind it
    i_valid = 1'b1; i_d = 8'h80; #1;
    chk("t3_ir_acc", i_ready, 1);
    tick();
    i_d = 8'h22;
    cyc = 0; zeros = 0; low = 0;
    while (cyc < 200) begin
      #1;
      if (o_valid && o_d == 7'h22) break;
      if (o_valid && o_d == 7'h00) zeros++;
      if (!i_ready) low++;
      tick();
      cyc++;
    end
    chk("t3_zeros", zeros, 128);
    chk("t3_irlow", low, 127);
    chk("t3_cycles", cyc, 128);
    i_valid = 1'b0; tick();
    chk("t3_idle_v", o_valid, 0);

    // T4 run of 4 under backpressure
    i_valid = 1'b1; i_d = 8'h84; o_ready = 1'b1; #1;
    chk("t4_ir_acc", i_ready, 1);
    tick();
    i_d = 8'h33;
    xfer = 0;
    for (int i = 0; i < 7; i++) begin
      o_ready = orpat[i]; #1;
      chk($sformatf("t4_ir%0d", i), i_ready, irexp[i]);
      if (o_valid && o_ready && o_d == 7'h00) xfer++;
      tick();
      if (i < 6) begin
        chk($sformatf("t4_v%0d", i), o_valid, 1);
        chk($sformatf("t4_d%0d", i), o_d, 0);
      end
    end
    chk("t4_xfer", xfer, 4);
    chk("t4_lit", o_d, 7'h33);
    o_ready = 1'b1; i_valid = 1'b0; tick();

    // T5 reset in the middle of a run of 10
    i_valid = 1'b1; i_d = 8'h8A; #1;
    chk("t5_ir_acc", i_ready, 1);
    tick(); i_valid = 1'b0;
    tick(); chk("t5_z2", o_d, 0); chk("t5_v2", o_valid, 1);
    reset = 1'b0;
    tick();
    chk("t5_rst_v", o_valid, 0); chk("t5_rst_ra", run_active, 0);
    chk("t5_rst_ir", i_ready, 0);
    reset = 1'b1; i_valid = 1'b1; i_d = 8'h11; #1;
    chk("t5_ir", i_ready, 1);
    tick(); chk("t5_lit", o_d, 7'h11); chk("t5_lv", o_valid, 1);
    i_valid = 1'b0;
    tick(); chk("t5_after_v", o_valid, 0);

    // T6 random tokens against a queue model (counters restart from this reset)
    reset = 1'b0; tick(); reset = 1'b1;
    m_tok = 0; m_zero = 0;
    cur_tok = gen_tok();
    for (int c = 0; c < 600; c++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_d     = cur_tok;
      o_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (o_valid && o_ready) begin
        if (q.size() == 0) chk("t6_extra", o_valid, 0);
        else chk("t6_sym", o_d, q.pop_front());
      end
      if (i_valid && i_ready) begin
        m_tok++;
        if (!cur_tok[7]) begin
          q.push_back(cur_tok[6:0]);
          if (cur_tok[6:0] == 7'h00) m_zero++;
        end else begin
          len = (cur_tok[6:0] == 7'h00) ? 128 : int'(cur_tok[6:0]);
          for (int k = 0; k < len; k++) q.push_back(7'h00);
          m_zero += len;
        end
        cur_tok = gen_tok();
      end
      tick();
    end
    i_valid = 1'b0; o_ready = 1'b1;
    cyc = 0;
    while ((q.size() != 0 || o_valid) && cyc < 400) begin
      #1;
      if (o_valid) begin
        if (q.size() == 0) chk("t6_extra", o_valid, 0);
        else chk("t6_sym", o_d, q.pop_front());
      end
      tick();
      cyc++;
    end
    chk("t6_drained", q.size(), 0);
    chk("t6_idle_v", o_valid, 0);
`ifdef ZLE_DEC_STATS_EN
    chk("t6_n_tok", n_tok, m_tok);
    chk("t6_n_zero", n_zero, m_zero);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
